banco_controlador: RTL
======================

Name: banco_controlador

Overview:
Command-driven initiator for the two-read/one-write register bank.
- Accepts one ALU command per valid/ready handshake.
- Drives the bank read addresses and captures rs1/rs2.
- Computes the result and writes it back to the bank in a single-cycle write.
- Sits between a sequencer or testbench and the register bank; the bank port signals connect 1:1.

Parameters:
N, 6, register address width (bank depth 2**N)
W, 6, data width
SHW, $clog2(W), shift-amount width taken from rs2 LSBs

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when high with cmd_valid
cmd_op  input  3  operation code (see package)
cmd_rd  input  N  destination register
cmd_rs1  input  N  source register 1
cmd_rs2  input  N  source register 2
cmd_imm  input  W  immediate for LDI
we  output  1  bank write enable
data_in  output  W  bank write data
addr_rd  output  N  bank write address
addr_rs1  output  N  bank read address 1
addr_rs2  output  N  bank read address 2
rs1  input  W  bank read data 1 (combinational from addr_rs1)
rs2  input  W  bank read data 2
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse when a command completes
err  output  1  one-cycle pulse on illegal opcode
result  output  W  last completed result, held
flag_z  output  1  last result == 0
flag_c  output  1  carry (ADD) / borrow (SUB)

Behaviour:
- Reset (sync, rst sampled high at posedge): state=IDLE; we=0, data_in=0, all addr=0, done=0, err=0, result=0, flag_z=0, flag_c=0, busy=0. cmd_ready=1 after reset.
- Reset mid-operation: next edge forces IDLE. In-flight command dropped: no write, no done. we is low in the cycle after the reset edge.
- FSM IDLE -> READ -> EXEC -> WRITE -> IDLE; fixed 4-cycle latency; throughput 1 command per 4 cycles.
- IDLE: cmd_ready=1.
  - On cmd_valid & cmd_ready: latch op, rd, rs1, rs2, imm.
  - Go to READ.
  - cmd_* inputs are ignored in all other states.
- READ: addr_rs1/addr_rs2 = latched values. Register rs1/rs2 into operand registers at the end of the cycle.
- EXEC: compute on the operands; register result, flag_z, flag_c.
- WRITE: addr_rd=rd, data_in=result, we=1 for exactly one cycle; done=1 the same cycle.
  - If rd==0: we stays 0 (register 0 is hard zero); done still pulses and flags still update.
- Operations, all computed at W+1 bits and truncated to W:
  - ADD: rs1+rs2; flag_c = bit W.
  - SUB: rs1-rs2; flag_c = (rs1<rs2).
  - AND, OR, XOR: bitwise; flag_c=0.
  - SHL, SHR: logical shift by rs2[SHW-1:0]; amount >= W gives 0; flag_c=0.
  - LDI: result = imm; operands ignored; flag_c=0.
- Opcode 7 without CTRL_MUL_EN is illegal:
  - EXEC pulses err=1 for one cycle.
  - FSM returns directly to IDLE: no WRITE state, no done.
  - result and flags keep their previous values.
- Outside WRITE: we=0. addr_rd and data_in hold their last values.
- busy = (state != IDLE).

Optional Feature:
CTRL_MUL_EN
- Defined: opcode 7 = MUL, result = low W bits of rs1*rs2, flag_c = OR of the high W product bits. Latency unchanged (single-cycle multiplier in EXEC).
- Undefined: opcode 7 is illegal as described above; no multiplier is instantiated.

Decomposition:
- Package ctrl_pkg:
  - Constants N, W.
  - typedef enum logic [2:0] op_e: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SHL=5, SHR=6, LDI/MUL=7.
  - LDI is encoded through a spare bit pattern; final encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SHL=5, SHR=6, MUL=7, and LDI is SHR with rs2 field all-ones.
  - typedef enum state_e {IDLE, READ, EXEC, WRITE}.
- One combinational sub-module: ctrl_alu (op, a, b, imm -> result, carry, illegal). The FSM and registers stay in banco_controlador.

Test Plan:
- After reset: cmd_ready=1, we=0, busy=0, result=0, flags=0.
- Preload r3=45, r4=30; ADD rd=5, rs1=3, rs2=4 -> 4 cycles after accept: we=1, addr_rd=5, data_in=11, flag_c=1, flag_z=0, done pulse.
- Preload r1=5, r2=9; SUB rd=6 -> data_in=60, flag_c=1. Then XOR r1,r1 -> data_in=0, flag_z=1.
- Write to rd=0 -> done pulses, we never asserted, result updated.
- cmd_valid held high with two queued commands -> second is accepted exactly 4 cycles after the first; cmd_ready=0 while busy.
- rst asserted during EXEC -> no we, no done; IDLE and cmd_ready=1 the next cycle.
- Opcode 7: without CTRL_MUL_EN -> err pulse, no we, flags unchanged. With CTRL_MUL_EN and r1=7, r2=9 -> data_in=63, flag_c=0.

Source files
------------

// File: rtl/banco_controlador_pkg.sv
// Shared types and constants for the register-bank command controller.
// Contents:
//   N, W, SHW  : address width, data width, shift-amount width
//   op_e       : 3-bit command opcode
//   state_e    : controller FSM state
//   is_ldi()   : decodes LDI, which rides on the SHR opcode with an all-ones rs2 field
// Optional build macro CTRL_MUL_EN changes the meaning of OP_MUL (see banco_controlador_alu).
package banco_controlador_pkg;

  localparam int N   = 6;
  localparam int W   = 6;
  localparam int SHW = $clog2(W);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_e;

  // LDI has no opcode of its own: a shift right whose rs2 field is all ones
  // is taken as "load immediate".
  function automatic logic is_ldi(op_e op, logic [N-1:0] rs2_field);
    return (op == OP_SHR) && (&rs2_field);
  endfunction

endpackage

// File: rtl/banco_controlador_if.sv
// Interface bundling the command handshake, register-bank port and status
// outputs of banco_controlador.
//   master : the controller (accepts commands, drives bank addresses/write)
//   slave  : the environment (sequencer + register bank)
// Signals: cmd_valid/cmd_ready/cmd_op/cmd_rd/cmd_rs1/cmd_rs2/cmd_imm,
//          we/data_in/addr_rd/addr_rs1/addr_rs2/rs1/rs2,
//          busy/done/err/result/flag_z/flag_c.
interface banco_controlador_if;
  import banco_controlador_pkg::*;

  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [N-1:0] cmd_rd;
  logic [N-1:0] cmd_rs1;
  logic [N-1:0] cmd_rs2;
  logic [W-1:0] cmd_imm;

  logic         we;
  logic [W-1:0] data_in;
  logic [N-1:0] addr_rd;
  logic [N-1:0] addr_rs1;
  logic [N-1:0] addr_rs2;
  logic [W-1:0] rs1;
  logic [W-1:0] rs2;

  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] result;
  logic         flag_z;
  logic         flag_c;

  modport master (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rs1, rs2,
    output cmd_ready, we, data_in, addr_rd, addr_rs1, addr_rs2,
           busy, done, err, result, flag_z, flag_c
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rs1, rs2,
    input  cmd_ready, we, data_in, addr_rd, addr_rs1, addr_rs2,
           busy, done, err, result, flag_z, flag_c
  );

endinterface

// File: rtl/banco_controlador_alu.sv
// Combinational ALU for banco_controlador.
// Ports:
//   op_i      : opcode
//   ldi_i     : command is LDI (overrides op_i)
//   a_i, b_i  : operands (rs1, rs2)
//   imm_i     : immediate for LDI
//   result_o  : W-bit result
//   carry_o   : carry (ADD), borrow (SUB), high-product OR (MUL), else 0
//   illegal_o : opcode not supported in this build
// Build macro CTRL_MUL_EN: when defined OP_MUL multiplies; otherwise OP_MUL
// is reported illegal and no multiplier exists.
module banco_controlador_alu
  import banco_controlador_pkg::*;
(
  input  op_e          op_i,
  input  logic         ldi_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] imm_i,
  output logic [W-1:0] result_o,
  output logic         carry_o,
  output logic         illegal_o
);

  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [SHW-1:0] shamt;
  logic           sh_oob;

  assign sum    = {1'b0, a_i} + {1'b0, b_i};
  // Zero-extended subtraction: bit W is set exactly when a_i < b_i.
  assign diff   = {1'b0, a_i} - {1'b0, b_i};
  assign shamt  = b_i[SHW-1:0];
  // SHW bits can encode amounts >= W when W is not a power of two.
  assign sh_oob = (int'(shamt) >= W);

`ifdef CTRL_MUL_EN
  logic [2*W-1:0] prod;
  assign prod = (2*W)'(a_i) * (2*W)'(b_i);
`endif

  always_comb begin
    result_o  = '0;
    carry_o   = 1'b0;
    illegal_o = 1'b0;
    if (ldi_i) begin
      result_o = imm_i;
    end else begin
      case (op_i)
        OP_ADD: begin
          result_o = sum[W-1:0];
          carry_o  = sum[W];
        end
        OP_SUB: begin
          result_o = diff[W-1:0];
          carry_o  = diff[W];
        end
        OP_AND: result_o = a_i & b_i;
        OP_OR:  result_o = a_i | b_i;
        OP_XOR: result_o = a_i ^ b_i;
        OP_SHL: result_o = sh_oob ? '0 : (a_i << shamt);
        OP_SHR: result_o = sh_oob ? '0 : (a_i >> shamt);
        OP_MUL: begin
`ifdef CTRL_MUL_EN
          result_o = prod[W-1:0];
          carry_o  = |prod[2*W-1:W];
`else
          illegal_o = 1'b1;
`endif
        end
        default: result_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/banco_controlador.sv
// Command-driven initiator for a two-read/one-write register bank.
// Takes one ALU command per valid/ready handshake, reads rs1/rs2 from the
// bank, computes, and writes the result back in a single-cycle write.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : banco_controlador_if.master (command, bank port, status)
// Build macro CTRL_MUL_EN enables OP_MUL (handled inside banco_controlador_alu);
// without it opcode 7 pulses err and the command is dropped.
//
// state | meaning
// IDLE  | cmd_ready high, latch command on handshake
// READ  | drive read addresses, capture rs1/rs2 into operand regs
// EXEC  | compute, register result/flags (or pulse err on illegal op)
// WRITE | we (unless rd==0) and done for one cycle
module banco_controlador
  import banco_controlador_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  banco_controlador_if.master bus
);

  state_e       state_q, state_d;
  op_e          op_q;
  logic         ldi_q;
  logic [N-1:0] rd_q;
  logic [N-1:0] rs1a_q;
  logic [N-1:0] rs2a_q;
  logic [W-1:0] imm_q;
  logic [W-1:0] opa_q;
  logic [W-1:0] opb_q;
  logic [W-1:0] result_q;
  logic         flag_z_q;
  logic         flag_c_q;
  logic [N-1:0] addr_rd_q;

  logic [W-1:0] alu_res;
  logic         alu_c;
  logic         alu_illegal;

  banco_controlador_alu u_alu (
    .op_i      (op_q),
    .ldi_i     (ldi_q),
    .a_i       (opa_q),
    .b_i       (opb_q),
    .imm_i     (imm_q),
    .result_o  (alu_res),
    .carry_o   (alu_c),
    .illegal_o (alu_illegal)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cmd_valid) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = alu_illegal ? IDLE : WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_ADD;
      ldi_q     <= 1'b0;
      rd_q      <= '0;
      rs1a_q    <= '0;
      rs2a_q    <= '0;
      imm_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      addr_rd_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.cmd_valid) begin
        op_q   <= op_e'(bus.cmd_op);
        ldi_q  <= is_ldi(op_e'(bus.cmd_op), bus.cmd_rs2);
        rd_q   <= bus.cmd_rd;
        rs1a_q <= bus.cmd_rs1;
        rs2a_q <= bus.cmd_rs2;
        imm_q  <= bus.cmd_imm;
      end
      if (state_q == READ) begin
        opa_q <= bus.rs1;
        opb_q <= bus.rs2;
      end
      // Illegal commands leave result, flags and write address untouched.
      if (state_q == EXEC && !alu_illegal) begin
        result_q  <= alu_res;
        flag_z_q  <= (alu_res == '0);
        flag_c_q  <= alu_c;
        addr_rd_q <= rd_q;
      end
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == WRITE);
  // Register 0 is hard zero in the bank: never write it.
  assign bus.we        = (state_q == WRITE) && (addr_rd_q != '0);
  assign bus.err       = (state_q == EXEC) && alu_illegal;
  assign bus.addr_rd   = addr_rd_q;
  assign bus.data_in   = result_q;
  assign bus.addr_rs1  = rs1a_q;
  assign bus.addr_rs2  = rs2a_q;
  assign bus.result    = result_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_c    = flag_c_q;

endmodule
